// File: rtl/seq_seek_ctrl_if.sv
// Control/status bundle between the DSP-side register block and the serial pattern seeker.
interface seq_seek_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
);
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_nmatch;
  logic [TO_W-1:0]  cfg_timeout;
  logic             start;
  logic             abort;
  logic             bit_vld;
  logic             bit_in;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic             timeout;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_pat, cfg_len, cfg_nmatch, cfg_timeout,
    output start, abort, bit_vld, bit_in,
    input  busy, match, match_cnt, done, timeout, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pat, cfg_len, cfg_nmatch, cfg_timeout,
    input  start, abort, bit_vld, bit_in,
    output busy, match, match_cnt, done, timeout, cfg_err
  );
endinterface

// File: rtl/seq_seek_ctrl.sv
// Serial pattern seeker controller: shadow config, arm/seek FSM, overlapping match counting,
// finish on match target, SEEK-cycle timeout or abort.
module seq_seek_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input logic            clk,
  input logic            rst,
  seq_seek_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, SEEK} state_t;

  localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);

  state_t           state, state_n;
  logic [PAT_W-1:0] sh_pat;
  logic [LEN_W-1:0] sh_len;
  logic [CNT_W-1:0] sh_nmatch;
  logic [TO_W-1:0]  sh_to;

  // Only PAT_W-1 past bits are stored; the newest bit completes the PAT_W-wide compare window.
  logic [PAT_W-2:0] hist, hist_n;
  logic [PAT_W-1:0] shifted, mask;
  logic [LEN_W-1:0] fill, fill_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TO_W-1:0]  cyc, cyc_n;
  logic             match_q, match_n, done_q, done_n;
  logic             timeout_q, timeout_n, cfg_err_q, cfg_err_n;
  logic             len_ok, hit, fin_cnt, fin_to;

  assign len_ok  = (sh_len != '0) && (sh_len <= PAT_LEN);
  assign shifted = {hist, bus.bit_in};

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < sh_len);
    end
  end

  always_comb begin
    state_n   = state;
    hist_n    = hist;
    fill_n    = fill;
    cnt_n     = cnt;
    cyc_n     = cyc;
    match_n   = 1'b0;
    done_n    = 1'b0;
    timeout_n = timeout_q;
    cfg_err_n = cfg_err_q;
    hit       = 1'b0;
    fin_cnt   = 1'b0;
    fin_to    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            state_n   = ARM;
            timeout_n = 1'b0;
            cfg_err_n = 1'b0;
          end else begin
            cfg_err_n = 1'b1;
          end
        end
      end
      ARM: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else begin
          hist_n  = '0;
          fill_n  = '0;
          cnt_n   = '0;
          cyc_n   = '0;
          state_n = SEEK;
        end
      end
      SEEK: begin
        if (bus.abort) begin
          state_n = IDLE;
        end else begin
          cyc_n = cyc + 1'b1;
          if (bus.bit_vld) begin
            hist_n = shifted[PAT_W-2:0];
            if (fill != PAT_LEN) fill_n = fill + 1'b1;
            hit = (fill_n >= sh_len) && ((shifted & mask) == (sh_pat & mask));
          end
          if (hit) begin
            match_n = 1'b1;
            if (cnt != '1) cnt_n = cnt + 1'b1;
          end
          // A final match in the same cycle as timeout wins: done without the timeout flag.
          fin_cnt = hit && (sh_nmatch != '0) && (cnt_n == sh_nmatch);
          fin_to  = (sh_to != '0) && (cyc_n == sh_to);
          if (fin_cnt || fin_to) begin
            done_n  = 1'b1;
            state_n = IDLE;
            if (!fin_cnt) timeout_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh_pat    <= '0;
      sh_len    <= '0;
      sh_nmatch <= '0;
      sh_to     <= '0;
      hist      <= '0;
      fill      <= '0;
      cnt       <= '0;
      cyc       <= '0;
      match_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      fill      <= fill_n;
      cnt       <= cnt_n;
      cyc       <= cyc_n;
      match_q   <= match_n;
      done_q    <= done_n;
      timeout_q <= timeout_n;
      cfg_err_q <= cfg_err_n;
      if (bus.cfg_we && state == IDLE) begin
        sh_pat    <= bus.cfg_pat;
        sh_len    <= bus.cfg_len;
        sh_nmatch <= bus.cfg_nmatch;
        sh_to     <= bus.cfg_timeout;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_seek_ctrl.sv
// Bench for seq_seek_ctrl: directed scenarios then random traffic, all against a queue-based model.
module tb_seq_seek_ctrl;
  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;
  localparam int TO_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_seek_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .TO_W(TO_W)) bus ();

  seq_seek_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = arm, 2 = seek; received bits kept as a queue.
  int       m_phase;
  bit       m_q[$];
  bit [7:0] m_pat;
  int       m_len, m_nm, m_to, m_cnt, m_cyc;
  bit       m_match, m_done, m_timeout, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_q.delete(); m_pat = '0; m_len = 0; m_nm = 0; m_to = 0;
    m_cnt = 0; m_cyc = 0; m_match = 0; m_done = 0; m_timeout = 0; m_err = 0;
  endtask

  function automatic bit pattern_seen();
    if (m_q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_q[m_q.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit hit, fin_n, fin_t;
    m_match = 0;
    m_done  = 0;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        if (bus.start) begin
          if (m_len >= 1 && m_len <= PAT_W) begin
            m_phase = 1; m_err = 0; m_timeout = 0;
          end else begin
            m_err = 1;
          end
        end
        if (bus.cfg_we) begin
          m_pat = bus.cfg_pat; m_len = int'(bus.cfg_len);
          m_nm = int'(bus.cfg_nmatch); m_to = int'(bus.cfg_timeout);
        end
      end
      1: begin
        if (bus.abort) m_phase = 0;
        else begin
          m_q.delete(); m_cnt = 0; m_cyc = 0; m_phase = 2;
        end
      end
      default: begin
        if (bus.abort) m_phase = 0;
        else begin
          m_cyc++;
          hit = 0;
          if (bus.bit_vld) begin
            m_q.push_back(bus.bit_in);
            if (m_q.size() > 16) void'(m_q.pop_front());
            hit = pattern_seen();
          end
          fin_n = 0;
          if (hit) begin
            m_match = 1;
            if (m_cnt < 255) m_cnt++;
            fin_n = (m_nm != 0) && (m_cnt == m_nm);
          end
          fin_t = (m_to != 0) && (m_cyc == m_to);
          if (fin_n || fin_t) begin
            m_done = 1; m_phase = 0;
            if (!fin_n) m_timeout = 1;
          end
        end
      end
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("busy",      32'(bus.busy),      32'(m_phase != 0));
    check("match",     32'(bus.match),     32'(m_match));
    check("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
    check("done",      32'(bus.done),      32'(m_done));
    check("timeout",   32'(bus.timeout),   32'(m_timeout));
    check("cfg_err",   32'(bus.cfg_err),   32'(m_err));
  endtask

  task automatic quiet();
    bus.cfg_we = 0; bus.start = 0; bus.abort = 0; bus.bit_vld = 0; bus.bit_in = 0;
  endtask

  task automatic write_cfg(input logic [7:0] pat, input int len, input int nm, input int to);
    bus.cfg_we = 1; bus.cfg_pat = pat; bus.cfg_len = LEN_W'(len);
    bus.cfg_nmatch = CNT_W'(nm); bus.cfg_timeout = TO_W'(to);
    cycle();
    bus.cfg_we = 0;
  endtask

  task automatic do_start();
    bus.start = 1;
    cycle();
    bus.start = 0;
    cycle();
  endtask

  task automatic send_bit(input bit b);
    bus.bit_vld = 1; bus.bit_in = b;
    cycle();
    bus.bit_vld = 0;
  endtask

  initial begin
    bit [6:0] s1;
    s1 = 7'b0110110;
    quiet();
    bus.cfg_pat = '0; bus.cfg_len = '0; bus.cfg_nmatch = '0; bus.cfg_timeout = '0;
    model_reset();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    cycle();
    check("reset_cnt", 32'(bus.match_cnt), 32'd0);

    // 1: overlapping matches, finish on second
    write_cfg(8'b0110, 4, 2, 0);
    do_start();
    for (int i = 6; i >= 0; i--) send_bit(s1[i]);
    check("t1_cnt",  32'(bus.match_cnt), 32'd2);
    check("t1_done", 32'(bus.done),      32'd1);
    check("t1_busy", 32'(bus.busy),      32'd0);
    cycle();

    // 2: gaps between qualified bits
    do_start();
    for (int i = 6; i >= 0; i--) begin
      send_bit(s1[i]);
      if (bus.busy) cycle();
    end
    check("t2_cnt", 32'(bus.match_cnt), 32'd2);

    // 3: timeout with no bits
    write_cfg(8'h00, 3, 0, 10);
    do_start();
    for (int i = 0; i < 12; i++) cycle();
    check("t3_timeout", 32'(bus.timeout),   32'd1);
    check("t3_cnt",     32'(bus.match_cnt), 32'd0);
    bus.start = 1;
    cycle();
    bus.start = 0;
    check("t3_clear", 32'(bus.timeout), 32'd0);
    bus.abort = 1;
    cycle();
    bus.abort = 0;

    // 4: run forever, abort after one match
    write_cfg(8'b0110, 4, 0, 0);
    do_start();
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    bus.abort = 1;
    cycle();
    bus.abort = 0;
    check("t4_busy", 32'(bus.busy),      32'd0);
    check("t4_done", 32'(bus.done),      32'd0);
    check("t4_cnt",  32'(bus.match_cnt), 32'd1);
    cycle();

    // 5: illegal lengths
    write_cfg(8'b1, 0, 1, 0);
    bus.start = 1; cycle(); bus.start = 0;
    check("t5_err0", 32'(bus.cfg_err), 32'd1);
    write_cfg(8'b1, 9, 1, 0);
    bus.start = 1; cycle(); bus.start = 0;
    check("t5_err9",  32'(bus.cfg_err), 32'd1);
    check("t5_busy",  32'(bus.busy),    32'd0);
    write_cfg(8'b1, 1, 1, 0);
    bus.start = 1; cycle(); bus.start = 0;
    check("t5_clear", 32'(bus.cfg_err), 32'd0);
    bus.abort = 1; cycle(); bus.abort = 0;

    // 6: cfg_we ignored while busy, then reset mid-search
    write_cfg(8'b0110, 4, 0, 0);
    do_start();
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    write_cfg(8'b1111, 2, 1, 3);
    send_bit(1); send_bit(1); send_bit(0);
    check("t6_cnt", 32'(bus.match_cnt), 32'd2);
    rst = 1;
    cycle();
    rst = 0;
    check("t6_busy", 32'(bus.busy),      32'd0);
    check("t6_cnt0", 32'(bus.match_cnt), 32'd0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      quiet();
      rst = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 99) < 6) begin
        bus.cfg_we = 1;
        bus.cfg_pat = 8'($urandom);
        bus.cfg_len = ($urandom_range(0, 9) < 8) ? LEN_W'($urandom_range(1, 4))
                                                 : LEN_W'($urandom_range(0, 15));
        bus.cfg_nmatch = CNT_W'($urandom_range(0, 5));
        bus.cfg_timeout = ($urandom_range(0, 1) == 1) ? TO_W'($urandom_range(1, 60)) : '0;
      end
      bus.start   = ($urandom_range(0, 99) < 8);
      bus.abort   = ($urandom_range(0, 99) < 2);
      bus.bit_vld = ($urandom_range(0, 99) < 65);
      bus.bit_in  = 1'($urandom);
      cycle();
    end
    rst = 0;
    quiet();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
